// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, mode constants, default word width
// and the sclk edge-role helper used by the slave.
package spi_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   // Mode encoding is {CPOL, CPHA}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Map raw sclk rise/fall pulses to {sample, shift} roles for a mode.
   // Leading edge leaves the CPOL idle level, trailing edge returns to it.
   function automatic logic [1:0] edge_select(input logic cpol,
                                              input logic cpha,
                                              input logic rise,
                                              input logic fall);
      logic leading;
      logic trailing;
      leading  = cpol ? fall : rise;
      trailing = cpol ? rise : fall;
      return cpha ? {trailing, leading} : {leading, trailing};
   endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the parallel transmit/receive bus of the slave.
interface spi_slave_if
   import spi_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             CPOL;
   logic             CPHA;
   logic             cs_n;
   logic             sclk;
   logic             MOSI;
   logic             MISO;
   logic             miso_en;
   logic [WIDTH-1:0] initialize_data;
   logic             load;
   logic [WIDTH-1:0] slave_data;
   logic             rx_valid;
   logic             busy;

   modport slave (
      input  CPOL, CPHA, cs_n, sclk, MOSI, initialize_data, load,
      output MISO, miso_en, slave_data, rx_valid, busy
   );

   modport master (
      output CPOL, CPHA, cs_n, sclk, MOSI, initialize_data, load,
      input  MISO, miso_en, slave_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with a registered copy of
// the synchronized level for rise/fall detection. SYNC_STAGES must be >= 2.
// Everything resets to 0, so a pin that is already low at reset release
// produces no fall pulse.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // Synchronizer chain and previous-level register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign level = sync_r[SYNC_STAGES-1];
   assign rise  = level & ~prev_r;
   assign fall  = ~level & prev_r;
endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversamples sclk/cs_n/MOSI into clk, deserializes MSB-first
// words and serializes the transmit buffer on MISO, in all four modes.
module spi_slave
   import spi_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input logic        clk,
   input logic        reset,
   spi_slave_if.slave bus
);
   localparam int               CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic sclk_level_s, sclk_rise_s, sclk_fall_s;
   logic cs_level_s, cs_rise_s, cs_fall_s;
   logic mosi_s, mosi_rise_s, mosi_fall_s;
   logic sample_s, shift_s;
   logic unused_s;
   logic [WIDTH-1:0] next_word_s;
   logic [WIDTH-1:0] rx_next_s;

   logic [0:0]       state_r;
   logic             cpol_r;
   logic             cpha_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] tx_buf_r;
   logic [WIDTH-1:0] tx_shift_r;
   logic [WIDTH-1:0] rx_shift_r;
   logic [WIDTH-1:0] slave_data_r;
   logic             rx_valid_r;
   logic             miso_r;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .reset(reset), .din(bus.sclk),
      .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .reset(reset), .din(bus.cs_n),
      .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .reset(reset), .din(bus.MOSI),
      .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
   );

   // Only the edge pulses of sclk/cs_n and the level of MOSI are needed
   assign unused_s = sclk_level_s ^ cs_level_s ^ mosi_rise_s ^ mosi_fall_s;

   assign {sample_s, shift_s} = edge_select(cpol_r, cpha_r, sclk_rise_s, sclk_fall_s);

   // A load in the same cycle as a reload wins over the stored buffer
   assign next_word_s = bus.load ? bus.initialize_data : tx_buf_r;
   assign rx_next_s   = {rx_shift_r[WIDTH-2:0], mosi_s};

   // Transfer FSM, shift registers, bit counter and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         cpol_r       <= 1'b0;
         cpha_r       <= 1'b0;
         cnt_r        <= ZERO;
         tx_buf_r     <= {WIDTH{1'b0}};
         tx_shift_r   <= {WIDTH{1'b0}};
         rx_shift_r   <= {WIDTH{1'b0}};
         slave_data_r <= {WIDTH{1'b0}};
         rx_valid_r   <= 1'b0;
         miso_r       <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         if (bus.load) begin
            tx_buf_r <= bus.initialize_data;
         end else begin
            tx_buf_r <= tx_buf_r;
         end
         case (state_r)
            ST_IDLE: begin
               miso_r <= 1'b0;
               if (cs_fall_s) begin
                  cpol_r     <= bus.CPOL;
                  cpha_r     <= bus.CPHA;
                  tx_shift_r <= next_word_s;
                  miso_r     <= next_word_s[WIDTH-1];
                  cnt_r      <= ZERO;
                  state_r    <= ST_ACTIVE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACTIVE: begin
               if (sample_s) begin
                  rx_shift_r <= rx_next_s;
                  if (cnt_r == LAST) begin
                     slave_data_r <= rx_next_s;
                     rx_valid_r   <= 1'b1;
                     cnt_r        <= ZERO;
                     tx_shift_r   <= next_word_s;
                  end else begin
                     cnt_r <= cnt_r + ONE;
                  end
               end else begin
                  rx_shift_r <= rx_shift_r;
               end
               // First shift edge of a word only presents the MSB
               if (shift_s) begin
                  if (cnt_r == ZERO) begin
                     miso_r <= tx_shift_r[WIDTH-1];
                  end else begin
                     tx_shift_r <= {tx_shift_r[WIDTH-2:0], 1'b0};
                     miso_r     <= tx_shift_r[WIDTH-2];
                  end
               end else begin
                  miso_r <= miso_r;
               end
               // Deselect last so a coincident final sample still completes
               if (cs_rise_s) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= ZERO;
                  miso_r  <= 1'b0;
               end else begin
                  state_r <= ST_ACTIVE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= ZERO;
               miso_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.MISO       = miso_r;
   assign bus.miso_en    = (state_r == ST_ACTIVE);
   assign bus.busy       = (state_r == ST_ACTIVE);
   assign bus.slave_data = slave_data_r;
   assign bus.rx_valid   = rx_valid_r;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave acting as SPI master. Expected received words
// go into a queue; a monitor pops and compares on every rx_valid.
module tb_spi_slave;
   import spi_pkg::*;

   localparam int HALF = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   spi_slave_if #(.WIDTH(8)) bus ();

   spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   int errors = 0;
   int checks = 0;
   int rx_pulses = 0;
   logic mon_prev = 1'b0;
   logic [7:0] exp_rx_q[$];
   logic [7:0] w1, w2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_word(input logic [7:0] d);
      @(negedge clk);
      bus.initialize_data = d;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic cs_begin(input logic cpol, input logic cpha);
      bus.CPOL = cpol;
      bus.CPHA = cpha;
      bus.sclk = cpol;
      wait_clks(HALF);
      bus.cs_n = 1'b0;
      wait_clks(HALF);
   endtask

   task automatic cs_end();
      wait_clks(HALF);
      bus.cs_n = 1'b1;
      wait_clks(HALF);
   endtask

   // Shift nbits MSB-first; MISO is sampled just before each slave sample edge
   task automatic spi_word(input logic [7:0] mosi_word, input logic cpol,
                           input logic cpha, input int nbits,
                           output logic [7:0] miso_word);
      miso_word = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) begin
            bus.MOSI = mosi_word[i];
            wait_clks(HALF);
            miso_word[i] = bus.MISO;
            bus.sclk = ~cpol;
            wait_clks(HALF);
            bus.sclk = cpol;
         end else begin
            bus.sclk = ~cpol;
            bus.MOSI = mosi_word[i];
            wait_clks(HALF);
            miso_word[i] = bus.MISO;
            bus.sclk = cpol;
            wait_clks(HALF);
         end
      end
   endtask

   // Scoreboard monitor: one pop/compare per rx_valid pulse
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (bus.rx_valid) begin
            if (mon_prev) begin
               checks++;
               errors++;
               $display("FAIL rx_valid_width: actual=multi-cycle expected=1 cycle");
            end else begin
               rx_pulses++;
               if (exp_rx_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rx_valid: actual=%0h expected=no pulse", bus.slave_data);
               end else begin
                  check("rx_word", 32'(bus.slave_data), 32'(exp_rx_q.pop_front()));
               end
            end
         end
         mon_prev = bus.rx_valid;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [1:0] modes [3];
      modes = '{MODE1, MODE2, MODE3};
      bus.CPOL = 1'b0;
      bus.CPHA = 1'b0;
      bus.cs_n = 1'b1;
      bus.sclk = 1'b0;
      bus.MOSI = 1'b0;
      bus.initialize_data = 8'h00;
      bus.load = 1'b0;

      // Reset state
      wait_clks(3);
      check("rst_miso", 32'(bus.MISO), 32'h0);
      check("rst_miso_en", 32'(bus.miso_en), 32'h0);
      check("rst_slave_data", 32'(bus.slave_data), 32'h0);
      check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      reset = 1'b1;
      wait_clks(5);

      // Mode 0 basic transfer
      load_word(8'hA5);
      exp_rx_q.push_back(8'h3C);
      cs_begin(1'b0, 1'b0);
      check("m0_busy", 32'(bus.busy), 32'h1);
      check("m0_miso_en", 32'(bus.miso_en), 32'h1);
      check("m0_first_bit", 32'(bus.MISO), 32'h1);
      spi_word(8'h3C, 1'b0, 1'b0, 8, w1);
      check("m0_tx_word", 32'(w1), 32'hA5);
      cs_end();
      check("m0_idle_busy", 32'(bus.busy), 32'h0);
      check("m0_idle_miso_en", 32'(bus.miso_en), 32'h0);
      check("m0_idle_miso", 32'(bus.MISO), 32'h0);
      check("m0_pulses", 32'(rx_pulses), 32'd1);

      // Modes 1..3 with all-ones / all-zeros patterns
      for (int m = 0; m < 3; m++) begin
         load_word(8'h00);
         exp_rx_q.push_back(8'hFF);
         cs_begin(modes[m][1], modes[m][0]);
         spi_word(8'hFF, modes[m][1], modes[m][0], 8, w1);
         cs_end();
         check("mode_tx_00", 32'(w1), 32'h00);
         load_word(8'hFF);
         exp_rx_q.push_back(8'h00);
         cs_begin(modes[m][1], modes[m][0]);
         spi_word(8'h00, modes[m][1], modes[m][0], 8, w1);
         cs_end();
         check("mode_tx_ff", 32'(w1), 32'hFF);
      end
      check("modes_pulses", 32'(rx_pulses), 32'd7);

      // Back-to-back words, load during the first word
      load_word(8'h11);
      exp_rx_q.push_back(8'h01);
      exp_rx_q.push_back(8'h80);
      cs_begin(1'b0, 1'b0);
      fork
         spi_word(8'h01, 1'b0, 1'b0, 8, w1);
         begin
            wait_clks(40);
            load_word(8'h55);
         end
      join
      spi_word(8'h80, 1'b0, 1'b0, 8, w2);
      cs_end();
      check("b2b_tx_first", 32'(w1), 32'h11);
      check("b2b_tx_second", 32'(w2), 32'h55);
      check("b2b_pulses", 32'(rx_pulses), 32'd9);

      // Partial word discarded, then a full word
      cs_begin(1'b0, 1'b0);
      spi_word(8'hFF, 1'b0, 1'b0, 5, w1);
      cs_end();
      check("partial_pulses", 32'(rx_pulses), 32'd9);
      check("partial_slave_data", 32'(bus.slave_data), 32'h80);
      check("partial_busy", 32'(bus.busy), 32'h0);
      load_word(8'h96);
      exp_rx_q.push_back(8'hC3);
      cs_begin(1'b0, 1'b0);
      spi_word(8'hC3, 1'b0, 1'b0, 8, w1);
      cs_end();
      check("after_partial_tx", 32'(w1), 32'h96);
      check("after_partial_pulses", 32'(rx_pulses), 32'd10);

      // Asynchronous reset mid-byte, select left low across release
      load_word(8'h5A);
      cs_begin(1'b0, 1'b0);
      spi_word(8'hFF, 1'b0, 1'b0, 4, w1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("arst_miso", 32'(bus.MISO), 32'h0);
      check("arst_miso_en", 32'(bus.miso_en), 32'h0);
      check("arst_slave_data", 32'(bus.slave_data), 32'h0);
      check("arst_rx_valid", 32'(bus.rx_valid), 32'h0);
      check("arst_busy", 32'(bus.busy), 32'h0);
      wait_clks(3);
      reset = 1'b1;
      wait_clks(HALF);
      spi_word(8'hFF, 1'b0, 1'b0, 8, w1);
      wait_clks(HALF);
      check("stale_cs_busy", 32'(bus.busy), 32'h0);
      check("stale_cs_pulses", 32'(rx_pulses), 32'd10);
      check("stale_cs_slave_data", 32'(bus.slave_data), 32'h0);
      cs_end();
      exp_rx_q.push_back(8'h5A);
      cs_begin(1'b0, 1'b0);
      spi_word(8'h5A, 1'b0, 1'b0, 8, w1);
      cs_end();
      check("post_reset_tx", 32'(w1), 32'h00);
      check("post_reset_pulses", 32'(rx_pulses), 32'd11);

      // CPOL change while active is ignored
      load_word(8'h96);
      exp_rx_q.push_back(8'h69);
      cs_begin(1'b0, 1'b0);
      bus.CPOL = 1'b1;
      spi_word(8'h69, 1'b0, 1'b0, 8, w1);
      cs_end();
      bus.CPOL = 1'b0;
      check("latched_mode_tx", 32'(w1), 32'h96);
      check("latched_mode_pulses", 32'(rx_pulses), 32'd12);

      wait_clks(5);
      check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
